// File: rtl/ldpc_cnu_minsum.sv
// Min-sum check-node unit for LDPC decoding.
//
// Accepts one check row at a time: a start pulse latches the row degree, then
// `deg` variable-to-check messages arrive on vin (qualified by vin_vld, gaps
// allowed). The unit tracks the two smallest magnitudes, the position of the
// smallest, every input sign and the row parity. It then emits `deg`
// check-to-variable messages on consecutive cycles, scaled by 0.75.
//
// Ports
//   clk       - clock, all state on rising edge
//   reset     - synchronous active-high reset
//   start     - one-cycle pulse beginning a row (accepted in IDLE only)
//   deg       - row degree, sampled when start is accepted (must be >= 2)
//   vin_vld   - qualifies vin (used only while accumulating)
//   vin       - two's-complement input message
//   busy      - high from start acceptance through the last output beat
//   cout_vld  - qualifies cout / cout_idx
//   cout      - two's-complement output message
//   cout_idx  - position in the row of the current cout
//   done      - pulse with the last output beat
//   err       - pulse the cycle after a start with deg < 2
module ldpc_cnu_minsum #(
  parameter int unsigned D_WID = 8,
  parameter int unsigned DEG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DEG_W-1:0] deg,
  input  logic             vin_vld,
  input  logic [D_WID-1:0] vin,
  output logic             busy,
  output logic             cout_vld,
  output logic [D_WID-1:0] cout,
  output logic [DEG_W-1:0] cout_idx,
  output logic             done,
  output logic             err
);

  localparam int unsigned NSig = 2 ** DEG_W;
  localparam logic [D_WID-1:0] MaxMag = {1'b0, {(D_WID-1){1'b1}}};
  localparam logic [D_WID-1:0] MinCode = {1'b1, {(D_WID-1){1'b0}}};
  localparam logic [DEG_W-1:0] DegOne = DEG_W'(1);
  localparam logic [DEG_W-1:0] DegTwo = DEG_W'(2);

  typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

  state_e            state_q, state_d;
  logic [DEG_W-1:0]  deg_q, deg_d;
  logic [DEG_W-1:0]  cnt_q, cnt_d;
  logic [D_WID-1:0]  min1_q, min1_d;
  logic [D_WID-1:0]  min2_q, min2_d;
  logic [DEG_W-1:0]  idx1_q, idx1_d;
  logic              row_sign_q, row_sign_d;
  logic [NSig-1:0]   signs_q, signs_d;
  logic              busy_q, busy_d;
  logic              vld_q, vld_d;
  logic [D_WID-1:0]  cout_q, cout_d;
  logic [DEG_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              vin_sign;
  logic [D_WID-1:0]  vin_mag;
  logic              emit;
  logic [DEG_W-1:0]  out_sel;
  logic [D_WID-1:0]  out_m;
  logic [D_WID-1:0]  out_scaled;
  logic              out_sign;

  assign vin_sign = vin[D_WID-1];

  // The most-negative code has no positive counterpart; saturate it.
  always_comb begin
    vin_mag = vin;
    if (vin_sign) begin
      vin_mag = (vin == MinCode) ? MaxMag : (D_WID'(0) - vin);
    end
  end

  always_comb begin
    state_d    = state_q;
    deg_d      = deg_q;
    cnt_d      = cnt_q;
    min1_d     = min1_q;
    min2_d     = min2_q;
    idx1_d     = idx1_q;
    row_sign_d = row_sign_q;
    signs_d    = signs_q;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cout_d     = cout_q;
    idx_d      = idx_q;
    emit       = 1'b0;
    out_sel    = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (deg >= DegTwo) begin
            deg_d      = deg;
            cnt_d      = '0;
            min1_d     = MaxMag;
            min2_d     = MaxMag;
            idx1_d     = '0;
            row_sign_d = 1'b0;
            signs_d    = '0;
            state_d    = StAcc;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAcc: begin
        if (vin_vld) begin
          signs_d[cnt_q] = vin_sign;
          row_sign_d     = row_sign_q ^ vin_sign;
          cnt_d          = cnt_q + DegOne;
          if (vin_mag < min1_q) begin
            min2_d = min1_q;
            min1_d = vin_mag;
            idx1_d = cnt_q;
          end else if (vin_mag < min2_q) begin
            min2_d = vin_mag;
          end
          // Beat 0 is launched on the same edge as the last input, from the
          // freshly updated minima, so it appears the very next cycle.
          if (cnt_q == deg_q - DegOne) begin
            state_d = StOut;
            emit    = 1'b1;
            out_sel = '0;
          end
        end
      end
      StOut: begin
        if (idx_q == deg_q - DegOne) begin
          state_d = StIdle;
        end else begin
          emit    = 1'b1;
          out_sel = idx_q + DegOne;
        end
      end
      default: state_d = StIdle;
    endcase

    out_m      = (out_sel == idx1_d) ? min2_d : min1_d;
    out_scaled = out_m - (out_m >> 2);
    out_sign   = row_sign_d ^ signs_d[out_sel];

    if (emit) begin
      vld_d  = 1'b1;
      idx_d  = out_sel;
      cout_d = out_sign ? (D_WID'(0) - out_scaled) : out_scaled;
      done_d = (out_sel == deg_q - DegOne);
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      deg_q      <= '0;
      cnt_q      <= '0;
      min1_q     <= MaxMag;
      min2_q     <= MaxMag;
      idx1_q     <= '0;
      row_sign_q <= 1'b0;
      signs_q    <= '0;
      busy_q     <= 1'b0;
      vld_q      <= 1'b0;
      cout_q     <= '0;
      idx_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      deg_q      <= deg_d;
      cnt_q      <= cnt_d;
      min1_q     <= min1_d;
      min2_q     <= min2_d;
      idx1_q     <= idx1_d;
      row_sign_q <= row_sign_d;
      signs_q    <= signs_d;
      busy_q     <= busy_d;
      vld_q      <= vld_d;
      cout_q     <= cout_d;
      idx_q      <= idx_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy     = busy_q;
  assign cout_vld = vld_q;
  assign cout     = cout_q;
  assign cout_idx = idx_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ldpc_cnu_minsum.sv
// Self-checking bench for ldpc_cnu_minsum: expected beats are queued when a
// row is started and popped as the DUT emits them.
module tb_ldpc_cnu_minsum;

  localparam int unsigned DW = 8;
  localparam int unsigned GW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [GW-1:0] deg = '0;
  logic          vin_vld = 1'b0;
  logic [DW-1:0] vin = '0;
  logic          busy;
  logic          cout_vld;
  logic [DW-1:0] cout;
  logic [GW-1:0] cout_idx;
  logic          done;
  logic          err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int idx;
    int val;
    bit last;
  } exp_t;

  exp_t sb[$];

  ldpc_cnu_minsum #(.D_WID(DW), .DEG_W(GW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .deg      (deg),
    .vin_vld  (vin_vld),
    .vin      (vin),
    .busy     (busy),
    .cout_vld (cout_vld),
    .cout     (cout),
    .cout_idx (cout_idx),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference: saturating magnitudes, two smallest, sign parity.
  task automatic model(input int d, input int v[8], output int e[8]);
    int mag[8];
    int sg[8];
    int rs, m1, m2, i1, m, sc;
    rs = 0; m1 = 127; m2 = 127; i1 = 0;
    for (int i = 0; i < 8; i++) begin
      e[i] = 0; mag[i] = 0; sg[i] = 0;
    end
    for (int i = 0; i < d; i++) begin
      sg[i] = (v[i] < 0) ? 1 : 0;
      mag[i] = (v[i] == -128) ? 127 : ((v[i] < 0) ? -v[i] : v[i]);
      rs = rs ^ sg[i];
    end
    for (int i = 0; i < d; i++) begin
      if (mag[i] < m1) begin m2 = m1; m1 = mag[i]; i1 = i; end
      else if (mag[i] < m2) m2 = mag[i];
    end
    for (int j = 0; j < d; j++) begin
      m = (j == i1) ? m2 : m1;
      sc = m - m / 4;
      e[j] = ((rs ^ sg[j]) != 0) ? -sc : sc;
    end
  endtask

  task automatic run_row(input string nm, input int d, input int v[8], input int e[8],
                         input int gap, input bit poke, input bit b2b);
    exp_t x;
    int got;
    int cyc;
    logic [DW-1:0] ev;
    for (int i = 0; i < d; i++) begin
      x.idx = i; x.val = e[i]; x.last = (i == d - 1);
      sb.push_back(x);
    end
    @(posedge clk); #1;
    start = 1'b1; deg = GW'(d);
    @(posedge clk); #1;
    start = 1'b0; deg = '0;
    for (int i = 0; i < d; i++) begin
      for (int g = 0; g < gap; g++) begin
        vin_vld = 1'b0;
        vin = 8'h55;
        start = poke; deg = GW'(2);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || cout_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL %s gap busy/vld: got %b/%b want 1/0", nm, busy, cout_vld);
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      vin_vld = 1'b1;
      vin = DW'(v[i]);
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || cout_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL %s acc busy/vld: got %b/%b want 1/0", nm, busy, cout_vld);
      end
      @(posedge clk); #1;
    end
    vin_vld = 1'b0;
    got = 0;
    cyc = 0;
    while (got < d && cyc < d + 4) begin
      @(negedge clk);
      n_chk++;
      if (cout_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL %s beat %0d cout_vld: got %b want 1", nm, cyc, cout_vld);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL %s extra beat: idx %0d with empty scoreboard", nm, cout_idx);
      end else begin
        x = sb.pop_front();
        ev = DW'(x.val);
        got++;
        if (cout_idx !== GW'(x.idx)) begin
          n_fail++;
          $display("FAIL %s cout_idx: got %0d want %0d", nm, cout_idx, x.idx);
        end
        n_chk++;
        if (cout !== ev) begin
          n_fail++;
          $display("FAIL %s cout[%0d]: got %0d want %0d", nm, x.idx, $signed(cout), x.val);
        end
        n_chk++;
        if (done !== x.last || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s done/busy[%0d]: got %b/%b want %b/1", nm, x.idx, done, busy, x.last);
        end
      end
      cyc++;
      if (got < d) begin
        @(posedge clk); #1;
        start = poke && (cyc == 1);
        deg = GW'(2);
      end
    end
    start = 1'b0;
    n_chk++;
    if (got != d) begin
      n_fail++;
      $display("FAIL %s beat count: got %0d want %0d", nm, got, d);
    end
    if (!b2b) begin
      @(posedge clk); #1;
      @(negedge clk);
      ev = DW'(e[d-1]);
      n_chk++;
      if (cout_vld !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle vld/busy/done: got %b/%b/%b want 0/0/0", nm, cout_vld, busy,
                 done);
      end
      n_chk++;
      if (cout !== ev || cout_idx !== GW'(d - 1)) begin
        n_fail++;
        $display("FAIL %s hold: got %0d@%0d want %0d@%0d", nm, $signed(cout), cout_idx,
                 e[d-1], d - 1);
      end
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s scoreboard leftover: got %0d want 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy, cout_vld, done, err} !== 4'b0000 || cout !== '0 || cout_idx !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got b%b v%b d%b e%b c%0d i%0d want all 0", busy, cout_vld,
               done, err, cout, cout_idx);
    end
  endtask

  task automatic test_basic();
    int v[8];
    int e[8];
    v = '{10, -3, 7, -20, 0, 0, 0, 0};
    e = '{3, -6, 3, -3, 0, 0, 0, 0};
    run_row("basic", 4, v, e, 0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    int v[8];
    int e[8];
    v = '{-128, 100, 0, 0, 0, 0, 0, 0};
    e = '{75, -96, 0, 0, 0, 0, 0, 0};
    run_row("saturate", 2, v, e, 0, 1'b0, 1'b0);
  endtask

  task automatic test_tie();
    int v[8];
    int e[8];
    v = '{5, 5, 9, 0, 0, 0, 0, 0};
    e = '{4, 4, 4, 0, 0, 0, 0, 0};
    run_row("tie", 3, v, e, 0, 1'b0, 1'b0);
  endtask

  task automatic test_err();
    for (int k = 1; k >= 0; k--) begin
      @(posedge clk); #1;
      start = 1'b1; deg = GW'(k);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      n_chk++;
      if (err !== 1'b1 || busy !== 1'b0 || cout_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL err deg=%0d pulse: got e%b b%b v%b want 1/0/0", k, err, busy, cout_vld);
      end
      vin_vld = 1'b1; vin = 8'd7;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b0 || cout_vld !== 1'b0) begin
          n_fail++;
          $display("FAIL err deg=%0d after: got e%b b%b v%b want 0/0/0", k, err, busy, cout_vld);
        end
      end
      vin_vld = 1'b0;
    end
  endtask

  task automatic test_gaps();
    int v[8];
    int e[8];
    v = '{10, -3, 7, -20, 0, 0, 0, 0};
    e = '{3, -6, 3, -3, 0, 0, 0, 0};
    run_row("gaps", 4, v, e, 3, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    int v[8];
    int e[8];
    @(posedge clk); #1;
    start = 1'b1; deg = GW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    vin_vld = 1'b1; vin = 8'd10;
    @(posedge clk); #1;
    vin = 8'hFD;
    @(posedge clk); #1;
    vin_vld = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || cout_vld !== 1'b0 || cout !== '0 || cout_idx !== '0) begin
      n_fail++;
      $display("FAIL rstmid: got b%b v%b c%0d i%0d want 0/0/0/0", busy, cout_vld, cout,
               cout_idx);
    end
    vin_vld = 1'b1; vin = 8'd7;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || cout_vld !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid quiet: got b%b v%b d%b want 0/0/0", busy, cout_vld, done);
      end
    end
    vin_vld = 1'b0;
    v = '{10, -3, 7, -20, 0, 0, 0, 0};
    e = '{3, -6, 3, -3, 0, 0, 0, 0};
    run_row("rerun", 4, v, e, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int v[8];
    int e[8];
    v = '{-128, 100, 0, 0, 0, 0, 0, 0};
    e = '{75, -96, 0, 0, 0, 0, 0, 0};
    run_row("b2b_a", 2, v, e, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) v[i] = int'($urandom_range(255)) - 128;
    v[6] = 0; v[7] = 0;
    model(6, v, e);
    run_row("b2b_b", 6, v, e, 0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_tie();
    test_err();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
